// File: rtl/icache_dm_refill.sv
// Direct-mapped, read-only instruction cache with line refill and whole-cache flush.
//
// Sits between the fetch stage and instruction memory. A fetch request is
// accepted in IDLE. A hit answers with a one-cycle response pulse in the
// cycle after acceptance. A miss issues one line-aligned memory request and
// takes WORDS_PER_LINE refill beats in ascending word order. It then answers
// with the requested word.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   flush                          invalidate every line (single-cycle pulse)
//   cpu_req_valid/ready/addr       fetch request (byte address, bits [1:0] ignored)
//   cpu_rsp_valid/data             one-cycle response pulse; data holds between pulses
//   mem_req_valid/ready/addr       line refill request (line-aligned byte address)
//   mem_rsp_valid/data             one refill beat per valid cycle
module icache_dm_refill #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned LINES          = 64,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    output logic              cpu_rsp_valid,
    output logic [DATA_W-1:0] cpu_rsp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data
);

    localparam int unsigned OffBits   = $clog2(WORDS_PER_LINE);
    localparam int unsigned OffW      = (OffBits > 0) ? OffBits : 1;
    localparam int unsigned IdxW      = $clog2(LINES);
    localparam int unsigned LineShift = 2 + OffBits;
    localparam int unsigned TagW      = ADDR_W - LineShift - IdxW;

    localparam logic [ADDR_W-1:0] OffMask  = ADDR_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] LineMask = ADDR_W'(4 * WORDS_PER_LINE - 1);
    localparam logic [OffW-1:0]   LastBeat = OffW'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StMissReq,
        StRefill,
        StRespond
    } state_e;

    function automatic logic [OffW-1:0] addr_off(input logic [ADDR_W-1:0] a);
        return OffW'((a >> 2) & OffMask);
    endfunction

    function automatic logic [IdxW-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return IdxW'(a >> LineShift);
    endfunction

    function automatic logic [TagW-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return TagW'(a >> (LineShift + IdxW));
    endfunction

    // Storage: only the valid bits carry reset.
    logic [DATA_W-1:0] data_mem [LINES][WORDS_PER_LINE];
    logic [TagW-1:0]   tag_mem  [LINES];
    logic [LINES-1:0]  valid_q;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [OffW-1:0]   cnt_q;
    logic              hit_q;
    logic              flush_pend_q;

    logic              cpu_req_ready_q;
    logic              cpu_rsp_valid_q;
    logic [DATA_W-1:0] cpu_rsp_data_q;
    logic              mem_req_valid_q;
    logic [ADDR_W-1:0] mem_req_addr_q;

    logic [OffW-1:0]   req_off, cur_off;
    logic [IdxW-1:0]   req_idx, cur_idx;
    logic [TagW-1:0]   req_tag, cur_tag;
    logic              lookup_hit;
    logic              beat_we;
    logic              last_beat;
    logic [DATA_W-1:0] fill_word;

    always_comb begin
        req_off = addr_off(cpu_req_addr);
        req_idx = addr_idx(cpu_req_addr);
        req_tag = addr_tag(cpu_req_addr);
        cur_off = addr_off(addr_q);
        cur_idx = addr_idx(addr_q);
        cur_tag = addr_tag(addr_q);

        // The tag compare runs on the incoming address. The hit response is then
        // already registered when LOOKUP starts. A coincident flush forces a miss.
        lookup_hit = !flush && valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

        beat_we   = (state_q == StRefill) && mem_rsp_valid;
        last_beat = (cnt_q == LastBeat);

        // The requested word may be the beat that is arriving right now.
        fill_word = (cnt_q == cur_off) ? mem_rsp_data : data_mem[cur_idx][cur_off];
    end

    always_ff @(posedge clk) begin
        if (beat_we) begin
            data_mem[cur_idx][cnt_q] <= mem_rsp_data;
            if (last_beat) begin
                tag_mem[cur_idx] <= cur_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            valid_q         <= '0;
            addr_q          <= '0;
            cnt_q           <= '0;
            hit_q           <= 1'b0;
            flush_pend_q    <= 1'b0;
            cpu_req_ready_q <= 1'b1;
            cpu_rsp_valid_q <= 1'b0;
            cpu_rsp_data_q  <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
        end else begin
            cpu_rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (flush) begin
                        valid_q <= '0;
                    end
                    if (cpu_req_valid) begin
                        addr_q          <= cpu_req_addr;
                        hit_q           <= lookup_hit;
                        cpu_req_ready_q <= 1'b0;
                        state_q         <= StLookup;
                        if (lookup_hit) begin
                            cpu_rsp_valid_q <= 1'b1;
                            cpu_rsp_data_q  <= data_mem[req_idx][req_off];
                        end
                    end
                end
                StLookup: begin
                    // Any hit response has already been sent. A flush here
                    // therefore only affects later lookups.
                    if (flush) begin
                        valid_q <= '0;
                    end
                    if (hit_q) begin
                        cpu_req_ready_q <= 1'b1;
                        state_q         <= StIdle;
                    end else begin
                        mem_req_valid_q <= 1'b1;
                        mem_req_addr_q  <= addr_q & ~LineMask;
                        state_q         <= StMissReq;
                    end
                end
                StMissReq: begin
                    if (flush) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        cnt_q           <= '0;
                        state_q         <= StRefill;
                    end
                end
                StRefill: begin
                    if (flush) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (mem_rsp_valid) begin
                        cnt_q <= cnt_q + OffW'(1);
                        if (last_beat) begin
                            valid_q[cur_idx] <= 1'b1;
                            cpu_rsp_valid_q  <= 1'b1;
                            cpu_rsp_data_q   <= fill_word;
                            state_q          <= StRespond;
                        end
                    end
                end
                StRespond: begin
                    // A flush seen during the miss is applied here, after the
                    // refilled line has already answered its own request.
                    if (flush_pend_q || flush) begin
                        valid_q      <= '0;
                        flush_pend_q <= 1'b0;
                    end
                    cpu_req_ready_q <= 1'b1;
                    state_q         <= StIdle;
                end
                default: begin
                    cpu_req_ready_q <= 1'b1;
                    state_q         <= StIdle;
                end
            endcase
        end
    end

    assign cpu_req_ready = cpu_req_ready_q;
    assign cpu_rsp_valid = cpu_rsp_valid_q;
    assign cpu_rsp_data  = cpu_rsp_data_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;

endmodule

// File: tb/tb_icache_dm_refill.sv
// Self-checking bench for icache_dm_refill (default parameters: 64 lines x 4 words).
// A behavioural memory responder serves refills with configurable handshake wait and
// beat gaps, and drives junk beats while no refill is in progress. Expected data,
// hit/miss and latency come from a line-level cache model kept in this file.
module tb_icache_dm_refill;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic [31:0] cpu_req_addr;
    logic        cpu_rsp_valid;
    logic [31:0] cpu_rsp_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    int tests = 0;
    int fails = 0;

    // Memory responder configuration and observations.
    int          cfg_wait   = 0;
    int          cfg_gap    = 0;
    int          req_count  = 0;
    int          beats_sent = 0;
    int          req_err    = 0;
    logic [31:0] req_addr   = 32'h0;

    // Cache model: which tag each line holds.
    bit          mvalid [64];
    int unsigned mtag   [64];

    icache_dm_refill #(
        .ADDR_W(32),
        .DATA_W(32),
        .LINES(64),
        .WORDS_PER_LINE(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .cpu_req_valid(cpu_req_valid),
        .cpu_req_ready(cpu_req_ready),
        .cpu_req_addr(cpu_req_addr),
        .cpu_rsp_valid(cpu_rsp_valid),
        .cpu_rsp_data(cpu_rsp_data),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: line 0 holds fixed words, everything else is a bijective hash.
    function automatic logic [31:0] img(input logic [31:0] a);
        logic [31:0] h;
        case (a)
            32'h0:   return 32'h2001_0002;
            32'h4:   return 32'h2002_0004;
            32'h8:   return 32'h2003_0006;
            32'hC:   return 32'h2004_0008;
            default: begin
                h = a * 32'h9E37_79B1;
                return h ^ 32'h5A5A_0F0F;
            end
        endcase
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    endfunction

    // Memory responder, driven on negedges. Phases: 0 idle (junk beats), 1 handshake
    // wait, 2 handshake done, 3 beats, 4 burst finished.
    initial begin
        int  phase;
        int  wait_left;
        int  gapc;
        bit  tgl;
        phase         = 0;
        wait_left     = 0;
        gapc          = 0;
        tgl           = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                phase         = 0;
                mem_req_ready = 1'b0;
                mem_rsp_valid = 1'b0;
            end else begin
                if (phase == 4) phase = 0;
                if (phase == 2) begin
                    mem_req_ready = 1'b0;
                    if (mem_req_valid !== 1'b0) req_err++;
                    phase = 3;
                end else if (phase == 3) begin
                    if (mem_req_valid !== 1'b0) req_err++;
                end
                if (phase == 3) begin
                    if (gapc != 0 && !tgl) begin
                        mem_rsp_valid = 1'b0;
                        mem_rsp_data  = $urandom;
                        tgl           = 1'b1;
                    end else begin
                        mem_rsp_valid = 1'b1;
                        mem_rsp_data  = img(req_addr + 32'(4 * beats_sent));
                        beats_sent++;
                        tgl = 1'b0;
                        if (beats_sent == 4) phase = 4;
                    end
                end else if (phase == 0) begin
                    mem_rsp_valid = 1'($urandom_range(0, 1));
                    mem_rsp_data  = $urandom;
                    if (mem_req_valid === 1'b1) begin
                        req_count++;
                        req_addr   = mem_req_addr;
                        wait_left  = cfg_wait;
                        gapc       = cfg_gap;
                        beats_sent = 0;
                        tgl        = 1'b0;
                        phase      = 1;
                    end
                end else if (phase == 1) begin
                    if (mem_req_valid !== 1'b1 || mem_req_addr !== req_addr) req_err++;
                end
                if (phase == 1) begin
                    if (wait_left == 0) begin
                        mem_req_ready = 1'b1;
                        phase         = 2;
                    end else begin
                        mem_req_ready = 1'b0;
                        wait_left--;
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    // One fetch. fl selects the cycle (counted from acceptance, 0 = with the request)
    // in which flush is pulsed; -1 means no flush.
    task automatic do_fetch(input logic [31:0] addr, input int w, input int g, input int fl,
                            input string nm);
        int unsigned idx;
        int unsigned tag;
        int          f;
        bit          exp_hit;
        int          exp_lat;
        logic [31:0] exp_data;
        logic [31:0] got_data;
        int          lat;
        int          reqs0;
        bit          got;
        idx      = (addr >> 4) & 63;
        tag      = addr >> 10;
        f        = fl;
        exp_hit  = (f != 0) && mvalid[idx] && (mtag[idx] == tag);
        if (exp_hit && f > 1) f = -1;
        exp_lat  = exp_hit ? 1 : 3 + w + ((g != 0) ? 8 : 4);
        exp_data = img(addr & ~32'h3);
        cfg_wait = w;
        cfg_gap  = g;
        reqs0    = req_count;

        @(negedge clk);
        tests++;
        if (cpu_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s ready_at_issue: got %b expected 1", nm, cpu_req_ready);
        end
        cpu_req_valid = 1'b1;
        cpu_req_addr  = addr;
        flush         = (f == 0);
        lat           = 0;
        got           = 1'b0;
        got_data      = 32'h0;
        while (!got && lat < 200) begin
            @(negedge clk);
            cpu_req_valid = 1'b0;
            cpu_req_addr  = $urandom;
            flush         = 1'b0;
            lat++;
            if (f == lat) flush = 1'b1;
            if (cpu_rsp_valid === 1'b1) begin
                got      = 1'b1;
                got_data = cpu_rsp_data;
            end
        end
        @(negedge clk);
        flush = 1'b0;

        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s response_timeout: no cpu_rsp_valid within %0d cycles", nm, lat);
        end
        tests++;
        if (got_data !== exp_data) begin
            fails++;
            $display("FAIL %s data: got %h expected %h", nm, got_data, exp_data);
        end
        tests++;
        if (lat != exp_lat) begin
            fails++;
            $display("FAIL %s latency: got %0d expected %0d", nm, lat, exp_lat);
        end
        tests++;
        if (cpu_rsp_valid !== 1'b0 || cpu_req_ready !== 1'b1 || cpu_rsp_data !== exp_data) begin
            fails++;
            $display("FAIL %s after_rsp: valid %b ready %b data %h expected 0 1 %h",
                     nm, cpu_rsp_valid, cpu_req_ready, cpu_rsp_data, exp_data);
        end
        tests++;
        if (req_count - reqs0 != (exp_hit ? 0 : 1)) begin
            fails++;
            $display("FAIL %s mem_requests: got %0d expected %0d", nm, req_count - reqs0,
                     exp_hit ? 0 : 1);
        end
        if (!exp_hit) begin
            tests++;
            if (req_addr !== (addr & ~32'hF) || beats_sent != 4 || req_err != 0) begin
                fails++;
                $display("FAIL %s refill: addr %h beats %0d handshake_errs %0d expected %h 4 0",
                         nm, req_addr, beats_sent, req_err, addr & ~32'hF);
            end
        end

        if (f == 0 || f == 1) model_clear();
        if (!exp_hit) begin
            mvalid[idx] = 1'b1;
            mtag[idx]   = tag;
        end
        if (f >= 2) model_clear();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (cpu_req_ready !== 1'b1 || cpu_rsp_valid !== 1'b0 || cpu_rsp_data !== 32'h0 ||
            mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: ready %b rsp_v %b rsp_d %h mreq_v %b mreq_a %h",
                     cpu_req_ready, cpu_rsp_valid, cpu_rsp_data, mem_req_valid, mem_req_addr);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        tests++;
        if (cpu_req_ready !== 1'b1 || cpu_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle: ready %b rsp_v %b mreq_v %b expected 1 0 0",
                     cpu_req_ready, cpu_rsp_valid, mem_req_valid);
        end
    endtask

    task automatic test_cold_line_hits();
        do_fetch(32'h0, 0, 0, -1, "cold_0");
        do_fetch(32'h4, 0, 0, -1, "hit_4");
        do_fetch(32'h8, 0, 0, -1, "hit_8");
        do_fetch(32'hC, 0, 0, -1, "hit_c");
    endtask

    task automatic test_critical_word();
        apply_reset();
        do_fetch(32'h8, 0, 0, -1, "cold_8");
    endtask

    task automatic test_conflict();
        do_fetch(32'h0,   0, 0, -1, "conflict_a");
        do_fetch(32'h400, 0, 0, -1, "conflict_b");
        do_fetch(32'h0,   0, 0, -1, "conflict_a2");
    endtask

    task automatic test_handshake_stress();
        do_fetch(32'h2044, 5, 1, -1, "stress");
    endtask

    task automatic test_flush();
        do_fetch(32'h0, 0, 0, -1, "flush_warm");
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_clear();
        do_fetch(32'h0,  0, 0, -1, "flush_idle_refetch");
        do_fetch(32'h40, 0, 0, 4,  "flush_in_refill");
        do_fetch(32'h40, 0, 0, -1, "after_refill_flush");
        do_fetch(32'h40, 0, 0, 1,  "flush_in_lookup_hit");
        do_fetch(32'h40, 0, 0, -1, "after_lookup_flush");
        do_fetch(32'h40, 0, 0, 0,  "flush_with_request");
        do_fetch(32'h40, 0, 0, -1, "after_request_flush");
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          r;
        int          fl;
        for (int i = 0; i < 40; i++) begin
            a = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 4) |
                (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            r  = $urandom_range(0, 9);
            fl = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? int'($urandom_range(2, 5)) : -1;
            do_fetch(a, $urandom_range(0, 3), $urandom_range(0, 1), fl, "random");
        end
    endtask

    task automatic test_reset_mid_refill();
        int r0;
        int n;
        r0       = req_count;
        cfg_wait = 0;
        cfg_gap  = 0;
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_addr  = 32'h1230;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        n = 0;
        while (!(req_count == r0 + 1 && beats_sent == 2) && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        tests++;
        if (n >= 40) begin
            fails++;
            $display("FAIL mid_refill_wait: beats %0d requests %0d expected 2 and %0d",
                     beats_sent, req_count - r0, 1);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (cpu_req_ready !== 1'b1 || cpu_rsp_valid !== 1'b0 || cpu_rsp_data !== 32'h0 ||
            mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0) begin
            fails++;
            $display("FAIL async_reset_outputs: ready %b rsp_v %b rsp_d %h mreq_v %b mreq_a %h",
                     cpu_req_ready, cpu_rsp_valid, cpu_rsp_data, mem_req_valid, mem_req_addr);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        do_fetch(32'h1230, 0, 0, -1, "after_abort");
    endtask

    initial begin
        flush         = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_req_addr  = 32'h0;
        model_clear();
        test_reset();
        test_cold_line_hits();
        test_critical_word();
        test_conflict();
        test_handshake_stress();
        test_flush();
        test_random();
        test_reset_mid_refill();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
